crc_checker: RTL and testbench

Serial CRC-8 checker for the receive end of the serial CRC link. It absorbs a payload bitstream qualified by `Active`, then absorbs the 8 received CRC bits, LSB first, qualified by `CRC_Valid`. It compares them against a locally computed CRC using the same polynomial and seed as the transmit-side generator. It reports a one-cycle `Done` pulse with a sticky `Error` flag per frame.

---
 rtl/crc_checker.sv | 103 ++++++++++
 tb/tb_crc_checker.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/crc_checker.sv
// crc_checker: serial CRC-8 receive checker that compares LSB-first received CRC bits against a locally computed CRC
// Ports: CLK rising-edge clock; RST async active-low reset
//        Data serial line; Active payload qualifier; CRC_Valid received-CRC qualifier
//        Done one-cycle completion pulse; Error frame result, held until next frame start; Busy frame in progress
module crc_checker #(
  parameter logic [7:0] SEED = 8'hD8
) (
  input  logic CLK,
  input  logic RST,
  input  logic Data,
  input  logic Active,
  input  logic CRC_Valid,
  output logic Done,
  output logic Error,
  output logic Busy
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;
  state_t     r_state, w_state_nx;
  logic [7:0] r_lfsr, w_lfsr_nx, w_step, w_shift;
  logic [2:0] r_cnt, w_cnt_nx;
  logic       r_err, w_err_nx, r_error, w_error_nx, r_done, r_busy, w_fb, w_mis;
  assign w_fb    = r_lfsr[0] ^ Data;
  assign w_step  = (r_lfsr >> 1) ^ (w_fb ? 8'hC4 : 8'h00);
  // Received CRC bits are compared against L[0] while the register drains toward the MSB-side zeros
  assign w_shift = {1'b0, r_lfsr[7:1]};
  assign w_mis   = Data ^ r_lfsr[0];
  always_comb begin
    w_state_nx = r_state;
    w_lfsr_nx  = r_lfsr;
    w_cnt_nx   = r_cnt;
    w_err_nx   = r_err;
    w_error_nx = r_error;
    case (r_state)
      IDLE: begin
        if (Active) begin
          w_lfsr_nx  = w_step;
          w_error_nx = 1'b0;
          w_state_nx = DATA;
        end else if (CRC_Valid) begin
          w_lfsr_nx  = w_shift;
          w_cnt_nx   = r_cnt + 3'd1;
          w_err_nx   = w_mis;
          w_error_nx = 1'b0;
          w_state_nx = CHECK;
        end
      end
      DATA: begin
        if (Active) begin
          w_lfsr_nx = w_step;
        end else if (CRC_Valid) begin
          w_lfsr_nx  = w_shift;
          w_cnt_nx   = r_cnt + 3'd1;
          w_err_nx   = r_err | w_mis;
          w_state_nx = CHECK;
        end
      end
      CHECK: begin
        if (Active) begin
          w_err_nx   = 1'b1;
          w_error_nx = 1'b1;
          w_state_nx = DONE;
        end else if (CRC_Valid) begin
          w_lfsr_nx = w_shift;
          w_cnt_nx  = r_cnt + 3'd1;
          w_err_nx  = r_err | w_mis;
          if (r_cnt == 3'd7) begin
            w_error_nx = r_err | w_mis;
            w_state_nx = DONE;
          end
        end
      end
      default: begin
        w_lfsr_nx  = SEED;
        w_cnt_nx   = 3'd0;
        w_err_nx   = 1'b0;
        w_state_nx = IDLE;
      end
    endcase
  end
  // Done and Busy are decoded from the next state so they line up with the state they describe
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_lfsr  <= SEED;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lfsr  <= w_lfsr_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
      r_error <= w_error_nx;
      r_done  <= (w_state_nx == DONE);
      r_busy  <= (w_state_nx == DATA) || (w_state_nx == CHECK);
    end
  end
  assign Done  = r_done;
  assign Error = r_error;
  assign Busy  = r_busy;
endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: scoreboard bench for crc_checker
module tb_crc_checker;
  logic CLK = 1'b0, RST = 1'b0, Data = 1'b0, Active = 1'b0, CRC_Valid = 1'b0;
  logic Done, Error, Busy;
  int   n_chk = 0, n_fail = 0;
  logic exp_q[$];

  crc_checker #(.SEED(8'hD8)) dut (
    .CLK(CLK), .RST(RST), .Data(Data), .Active(Active), .CRC_Valid(CRC_Valid),
    .Done(Done), .Error(Error), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] model(input logic [63:0] pay, input int n);
    logic [7:0] l, nl;
    logic fb;
    l = 8'hD8;
    for (int i = 0; i < n; i++) begin
      fb = l[0] ^ pay[i];
      nl[7] = fb;
      nl[6] = l[7] ^ fb;
      nl[5] = l[6];
      nl[4] = l[5];
      nl[3] = l[4];
      nl[2] = l[3] ^ fb;
      nl[1] = l[2];
      nl[0] = l[1];
      l = nl;
    end
    return l;
  endfunction

  task automatic drive(input logic a, input logic v, input logic d);
    @(negedge CLK);
    Active = a;
    CRC_Valid = v;
    Data = d;
  endtask

  task automatic send(input logic [63:0] pay, input int n, input logic [7:0] crc,
                      input int gap_mid, input int gap_at, input int gap_len, input bit both);
    exp_q.push_back(model(pay, n) !== crc);
    for (int i = 0; i < n; i++) drive(1'b1, both && (i >= n / 2), pay[i]);
    repeat (gap_mid) drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, crc[i]);
      if (i == gap_at) repeat (gap_len) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic end_frame(input logic a, input logic v, input logic dd,
                           output logic d, output logic e, output logic b, output logic x);
    @(negedge CLK);
    d = Done;
    e = Error;
    b = Busy;
    Active = a;
    CRC_Valid = v;
    Data = dd;
    x = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
  endtask

  task automatic test_reset();
    logic d, e, b, x;
    repeat (2) @(negedge CLK);
    n_chk++; if (Done !== 1'b0 || Error !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL reset_init: Done/Error/Busy=%b%b%b want 000", Done, Error, Busy); end
    RST = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_before: Busy=%b want 1", Busy); end
    #2 RST = 1'b0;
    #1;
    n_chk++; if (Done !== 1'b0 || Error !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL reset_async: Done/Error/Busy=%b%b%b want 000", Done, Error, Busy); end
    @(negedge CLK);
    Active = 1'b0;
    RST = 1'b1;
    send(64'd0, 8, 8'h14, 0, -1, 0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x) begin n_fail++; $display("FAIL reset_next_frame: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_good();
    logic d, e, b, x;
    send(64'd0, 8, 8'h14, 0, -1, 0, 1'b0);
    n_chk++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL good_busy: Busy=%b want 1", Busy); end
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1) begin n_fail++; $display("FAIL good_done: Done=%b want 1", d); end
    n_chk++; if (e !== x || x !== 1'b0) begin n_fail++; $display("FAIL good_error: Error=%b want %b", e, x); end
    n_chk++; if (b !== 1'b0) begin n_fail++; $display("FAIL good_busy_done: Busy=%b want 0", b); end
    @(negedge CLK);
    n_chk++; if (Done !== 1'b0) begin n_fail++; $display("FAIL good_pulse: Done=%b want 0", Done); end
  endtask

  task automatic test_corrupt();
    logic d, e, b, x;
    send(64'd0, 8, 8'h1C, 0, -1, 0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b1) begin n_fail++; $display("FAIL corrupt: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
    repeat (3) @(negedge CLK);
    n_chk++; if (Error !== 1'b1) begin n_fail++; $display("FAIL corrupt_sticky: Error=%b want 1", Error); end
    exp_q.push_back(1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    n_chk++; if (Error !== 1'b0 || Busy !== 1'b1) begin n_fail++; $display("FAIL corrupt_clear: Error=%b Busy=%b want Error=0 Busy=1", Error, Busy); end
    repeat (6) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, (i == 2) || (i == 4));
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x) begin n_fail++; $display("FAIL corrupt_next: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_zero_len();
    logic d, e, b, x;
    @(negedge CLK);
    send(64'd0, 0, 8'hD8, 0, -1, 0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b0) begin n_fail++; $display("FAIL zero_len_good: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
    send(64'd0, 0, 8'hD9, 0, -1, 0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b1) begin n_fail++; $display("FAIL zero_len_bad: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_gaps();
    logic d, e, b, x;
    send(64'd0, 8, 8'h14, 3, 4, 2, 1'b0);
    n_chk++; if (Done !== 1'b0) begin n_fail++; $display("FAIL gaps_early: Done=%b want 0", Done); end
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b0) begin n_fail++; $display("FAIL gaps: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_abort();
    logic d, e, b, x;
    @(negedge CLK);
    exp_q.push_back(1'b1);
    repeat (8) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, (i == 2) || (i == 4));
    drive(1'b1, 1'b0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x) begin n_fail++; $display("FAIL abort: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
    @(negedge CLK);
    n_chk++; if (Done !== 1'b0 || Busy !== 1'b0 || Error !== 1'b1) begin n_fail++; $display("FAIL abort_idle: Done/Busy/Error=%b%b%b want 001", Done, Busy, Error); end
    send(64'd0, 8, 8'h14, 0, -1, 0, 1'b0);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b0) begin n_fail++; $display("FAIL abort_recover: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_priority();
    logic d, e, b, x;
    send(64'd0, 8, 8'h14, 0, -1, 0, 1'b1);
    end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x || x !== 1'b0) begin n_fail++; $display("FAIL priority: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
  endtask

  task automatic test_back_to_back();
    logic d, e, b, x;
    logic [63:0] pay;
    logic [7:0] crc;
    int n;
    send(64'd0, 8, 8'h14, 0, -1, 0, 1'b0);
    end_frame(1'b1, 1'b1, 1'b1, d, e, b, x);
    n_chk++; if (d !== 1'b1 || e !== x) begin n_fail++; $display("FAIL b2b_first: Done=%b Error=%b want Done=1 Error=%b", d, e, x); end
    for (int k = 0; k < 8; k++) begin
      pay = {$urandom(), $urandom()};
      n = $urandom_range(1, 40);
      crc = model(pay, n);
      if (k % 3 == 1) crc[$urandom_range(0, 7)] ^= 1'b1;
      send(pay, n, crc, 0, -1, 0, 1'b0);
      end_frame(1'b0, 1'b0, 1'b0, d, e, b, x);
      n_chk++; if (d !== 1'b1 || e !== x) begin n_fail++; $display("FAIL b2b_frame%0d: Done=%b Error=%b want Done=1 Error=%b", k, d, e, x); end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_corrupt();
    test_zero_len();
    test_gaps();
    test_abort();
    test_priority();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
